io_bus_master: RTL and testbench
================================

IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 The block SHALL have parameter READ_LATENCY, default 1, meaning cycles from io_read_en to io_read_value sample; legal range 1..15.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port req_valid  input  1  CPU request present.
REQ-005 The block SHALL have port req_ready  output  1  block accepts request this cycle.
REQ-006 The block SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port req_addr  input  32  IO address.
REQ-008 The block SHALL have port req_wdata  input  32  store data.
REQ-009 The block SHALL have port rsp_valid  output  1  response present.
REQ-010 The block SHALL have port rsp_ready  input  1  CPU consumes response.
REQ-011 The block SHALL have port rsp_rdata  output  32  load data; 0 for store responses.
REQ-012 The block SHALL have port io_address  output  32  IO bus address.
REQ-013 The block SHALL have port io_write_value  output  32  IO bus write data.
REQ-014 The block SHALL have port io_write_en  output  1  one-cycle write strobe.
REQ-015 The block SHALL have port io_read_en  output  1  one-cycle read strobe.
REQ-016 The block SHALL have port io_read_value  input  32  registered read data from the IO responder.

Function
REQ-017 The block SHALL implement FSM states IDLE, WRITE, READ, WAIT, RESP; all outputs registered.
REQ-018 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-019 On req_valid&&req_ready, the block SHALL latch addr/wdata/write and go to WRITE (store) or READ (load).
REQ-020 In WRITE, io_write_en SHALL be 1 for exactly one cycle with io_address/io_write_value equal to the latched values; next state RESP.
REQ-021 In READ, io_read_en SHALL be 1 for exactly one cycle with io_address = latched address; the counter SHALL load READ_LATENCY-1; next state WAIT.
REQ-022 In WAIT, if counter==0 the block SHALL capture io_read_value into rsp_rdata and go to RESP; otherwise it SHALL decrement.
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_rdata stable until rsp_ready; on rsp_ready the block SHALL return to IDLE.
REQ-024 Load latency SHALL be accept edge + 1 (READ) + READ_LATENCY (WAIT) cycles to rsp_valid; store latency SHALL be 2 cycles.
REQ-025 io_write_en and io_read_en SHALL never both be 1; both SHALL be 0 outside WRITE/READ.
REQ-026 io_address and io_write_value SHALL hold their last driven values between transactions.
REQ-027 req_valid while req_ready=0 SHALL be ignored; the CPU holds it until accepted.
REQ-028 rsp_ready while rsp_valid=0 SHALL have no effect.

Reset
REQ-029 rst SHALL asynchronously force state IDLE, counter 0, and all outputs 0 except req_ready=1.
REQ-030 rst mid-transaction SHALL abort it, drop any strobe immediately, and produce no response.

Configuration
REQ-031 With IO_POSTED_WRITE_EN defined, WRITE SHALL go directly to IDLE and stores SHALL produce no response.
REQ-032 Without IO_POSTED_WRITE_EN, every store SHALL produce one response with rsp_rdata=0.

Structure
REQ-033 Package io_bus_pkg SHALL hold the FSM state typedef, IO_DATA_W=32, and the address constants IO_ADDR_SW=1, IO_ADDR_BTN=2, IO_ADDR_LED=4.
REQ-034 The latency counter SHALL be sub-module io_lat_counter (load, decrement, zero flag); the FSM SHALL stay in io_bus_master.

Verification
REQ-035 Load addr 1, responder returns 0x0000A5A5, READ_LATENCY=1 -> io_read_en pulses 1 cycle, rsp_valid 2 cycles after accept, rsp_rdata=0x0000A5A5.
REQ-036 Store addr 4, data 0x1234 -> one-cycle io_write_en with io_address=4 and io_write_value=0x1234; response rdata=0 (posted off) or no response (posted on).
REQ-037 READ_LATENCY=3, load addr 2 -> data sampled at the end of the 3rd WAIT cycle; an earlier-changing io_read_value SHALL not be captured.
REQ-038 rsp_ready held 0 for 5 cycles with req_valid=1 -> req_ready stays 0 and rsp_rdata stays stable; accepted the cycle after rsp_ready.
REQ-039 rst asserted during WAIT -> outputs 0, req_ready=1 and no rsp_valid; the next load completes normally.
REQ-040 Back-to-back store then load with rsp_ready=1 -> strobes never overlap, responses arrive in order.

Source files
------------

// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared widths, FSM state encoding and IO address map for the
// CPU-to-IO bus master.
package io_bus_pkg;

  localparam int unsigned IO_DATA_W = 32;
  localparam int unsigned IO_ADDR_W = 32;
  localparam int unsigned IO_CNT_W  = 4;

  // IO address map
  localparam logic [IO_ADDR_W-1:0] IO_ADDR_SW  = 32'd1;
  localparam logic [IO_ADDR_W-1:0] IO_ADDR_BTN = 32'd2;
  localparam logic [IO_ADDR_W-1:0] IO_ADDR_LED = 32'd4;

  // FSM state encoding
  typedef logic [2:0] io_state_t;
  localparam io_state_t ST_IDLE  = 3'd0;
  localparam io_state_t ST_WRITE = 3'd1;
  localparam io_state_t ST_READ  = 3'd2;
  localparam io_state_t ST_WAIT  = 3'd3;
  localparam io_state_t ST_RESP  = 3'd4;

  // Counter preload for a given read latency (WAIT lasts latency cycles)
  function automatic logic [IO_CNT_W-1:0] lat_preload(input int unsigned lat);
    return IO_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/io_lat_counter.sv
// io_lat_counter: down-counter timing the read-data wait window.
// Ports:
//   clk, rst : clock, async active-high reset (count -> 0)
//   load     : load value into the counter
//   dec      : decrement (saturates at 0)
//   value    : preload value
//   zero_c   : combinational flag, count == 0
module io_lat_counter
  import io_bus_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                dec,
  input  logic [IO_CNT_W-1:0] value,
  output logic                zero_c
);

  logic [IO_CNT_W-1:0] count;

  // Load has priority over decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - IO_CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/io_bus_master.sv
// io_bus_master: turns single CPU load/store requests into one-cycle IO bus
// strobes and returns one response per transaction.
// Config macro: IO_POSTED_WRITE_EN -- stores complete without a response.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   req_valid/req_ready       : CPU request handshake
//   req_write/addr/wdata      : request payload (1 = store)
//   rsp_valid/rsp_ready       : CPU response handshake
//   rsp_rdata                 : load data, 0 for store responses
//   io_address/io_write_value : IO bus address and write data (held)
//   io_write_en/io_read_en    : one-cycle IO strobes
//   io_read_value             : registered read data from the IO responder
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [IO_ADDR_W-1:0] req_addr,
  input  logic [IO_DATA_W-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IO_DATA_W-1:0] rsp_rdata,
  output logic [IO_ADDR_W-1:0] io_address,
  output logic [IO_DATA_W-1:0] io_write_value,
  output logic                 io_write_en,
  output logic                 io_read_en,
  input  logic [IO_DATA_W-1:0] io_read_value
);

  io_state_t            state, state_n;
  logic                 req_ready_n, rsp_valid_n, io_write_en_n, io_read_en_n;
  logic [IO_DATA_W-1:0] rsp_rdata_n, io_write_value_n;
  logic [IO_ADDR_W-1:0] io_address_n;
  logic                 cnt_load, cnt_dec, cnt_zero_c;

  io_lat_counter u_lat_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .value  (lat_preload(READ_LATENCY)),
    .zero_c (cnt_zero_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      io_address     <= '0;
      io_write_value <= '0;
      io_write_en    <= 1'b0;
      io_read_en     <= 1'b0;
    end else begin
      state          <= state_n;
      req_ready      <= req_ready_n;
      rsp_valid      <= rsp_valid_n;
      rsp_rdata      <= rsp_rdata_n;
      io_address     <= io_address_n;
      io_write_value <= io_write_value_n;
      io_write_en    <= io_write_en_n;
      io_read_en     <= io_read_en_n;
    end
  end

  // Next state and next output values; outputs reflect the state being entered
  always_comb begin
    state_n          = state;
    req_ready_n      = 1'b0;
    rsp_valid_n      = 1'b0;
    rsp_rdata_n      = rsp_rdata;
    io_address_n     = io_address;
    io_write_value_n = io_write_value;
    io_write_en_n    = 1'b0;
    io_read_en_n     = 1'b0;
    cnt_load         = 1'b0;
    cnt_dec          = 1'b0;

    case (state)
      ST_IDLE: begin
        req_ready_n = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_n  = 1'b0;
          io_address_n = req_addr;
          if (req_write) begin
            io_write_value_n = req_wdata;
            io_write_en_n    = 1'b1;
            state_n          = ST_WRITE;
          end else begin
            io_read_en_n = 1'b1;
            state_n      = ST_READ;
          end
        end
      end

      ST_WRITE: begin
`ifdef IO_POSTED_WRITE_EN
        req_ready_n = 1'b1;
        state_n     = ST_IDLE;
`else
        rsp_valid_n = 1'b1;
        rsp_rdata_n = '0;
        state_n     = ST_RESP;
`endif
      end

      ST_READ: begin
        cnt_load = 1'b1;
        state_n  = ST_WAIT;
      end

      // Capture only once the full latency has elapsed
      ST_WAIT: begin
        if (cnt_zero_c) begin
          rsp_rdata_n = io_read_value;
          rsp_valid_n = 1'b1;
          state_n     = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_RESP: begin
        rsp_valid_n = 1'b1;
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          req_ready_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end

      default: begin
        req_ready_n = 1'b1;
        state_n     = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: directed checks of io_bus_master with READ_LATENCY=1
// (u_dut1) and READ_LATENCY=3 (u_dut3); sel picks the active instance.
module tb_io_bus_master;
  import io_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic [31:0] rd_val    = '0;

  logic        rr1, rv1, we1, re1, rr3, rv3, we3, re3;
  logic [31:0] rd1, ad1, wv1, rd3, ad3, wv3;
  logic        o_req_ready, o_rsp_valid, o_we, o_re;
  logic [31:0] o_rdata, o_addr, o_wval;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_bus_master #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rr1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1),
    .io_address(ad1), .io_write_value(wv1), .io_write_en(we1),
    .io_read_en(re1), .io_read_value(rd_val)
  );

  io_bus_master #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rr3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_rdata(rd3),
    .io_address(ad3), .io_write_value(wv3), .io_write_en(we3),
    .io_read_en(re3), .io_read_value(rd_val)
  );

  always_comb begin
    o_req_ready = sel ? rr3 : rr1;
    o_rsp_valid = sel ? rv3 : rv1;
    o_we        = sel ? we3 : we1;
    o_re        = sel ? re3 : re1;
    o_rdata     = sel ? rd3 : rd1;
    o_addr      = sel ? ad3 : ad1;
    o_wval      = sel ? wv3 : wv1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Store already on the bus: check strobe, then complete it
  task automatic finish_store(input string tag);
    tick();
    chk({tag, "_we_drop"}, 32'(o_we), 32'd0);
`ifdef IO_POSTED_WRITE_EN
    chk({tag, "_no_rsp"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, "_ready"}, 32'(o_req_ready), 32'd1);
`else
    chk({tag, "_rsp_v"}, 32'(o_rsp_valid), 32'd1);
    chk({tag, "_rsp_d"}, o_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_done"}, 32'(o_rsp_valid), 32'd0);
`endif
  endtask

  logic [31:0] rsp_q[$];
  logic [31:0] exp_q[$];
  int          idx;
  logic        acc;

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_req_ready", 32'(rr1), 32'd1);
    chk("rst_rsp_valid", 32'(rv1), 32'd0);
    chk("rst_strobes", {30'd0, we1, re1}, 32'd0);
    chk("rst_addr", ad1, 32'd0);
    chk("rst_rdata", rd3, 32'd0);
    rst = 1'b0;
    tick();

    // Load addr 1, latency 1
    rd_val = 32'h0000_A5A5;
    req_valid = 1'b1; req_write = 1'b0; req_addr = IO_ADDR_SW;
    tick();
    req_valid = 1'b0;
    chk("ld1_re", 32'(o_re), 32'd1);
    chk("ld1_we", 32'(o_we), 32'd0);
    chk("ld1_addr", o_addr, 32'd1);
    chk("ld1_busy", 32'(o_req_ready), 32'd0);
    tick();
    chk("ld1_re_drop", 32'(o_re), 32'd0);
    chk("ld1_early_v", 32'(o_rsp_valid), 32'd0);
    tick();
    chk("ld1_rsp_v", 32'(o_rsp_valid), 32'd1);
    chk("ld1_rsp_d", o_rdata, 32'h0000_A5A5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("ld1_done_v", 32'(o_rsp_valid), 32'd0);
    chk("ld1_idle", 32'(o_req_ready), 32'd1);

    // Store addr 4, data 0x1234
    req_valid = 1'b1; req_write = 1'b1; req_addr = IO_ADDR_LED; req_wdata = 32'h1234;
    tick();
    req_valid = 1'b0;
    chk("st_we", 32'(o_we), 32'd1);
    chk("st_re", 32'(o_re), 32'd0);
    chk("st_addr", o_addr, 32'd4);
    chk("st_wval", o_wval, 32'h1234);
    finish_store("st");
    tick();
    chk("st_hold_addr", o_addr, 32'd4);
    chk("st_hold_wval", o_wval, 32'h1234);

    // Latency 3, early-changing read data is not captured
    sel = 1'b1;
    rd_val = 32'h1111;
    req_valid = 1'b1; req_write = 1'b0; req_addr = IO_ADDR_BTN;
    tick();
    req_valid = 1'b0;
    chk("ld3_re", 32'(o_re), 32'd1);
    chk("ld3_addr", o_addr, 32'd2);
    tick();
    rd_val = 32'hBAD1;
    tick();
    chk("ld3_wait2_v", 32'(o_rsp_valid), 32'd0);
    rd_val = 32'hBAD2;
    tick();
    chk("ld3_wait3_v", 32'(o_rsp_valid), 32'd0);
    rd_val = 32'hCAFE;
    tick();
    rd_val = 32'hDEAD;
    chk("ld3_rsp_v", 32'(o_rsp_valid), 32'd1);
    chk("ld3_rsp_d", o_rdata, 32'hCAFE);

    // Response back-pressure with a pending store request
    req_valid = 1'b1; req_write = 1'b1; req_addr = IO_ADDR_LED; req_wdata = 32'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", 32'(o_req_ready), 32'd0);
      chk("bp_rdata", o_rdata, 32'hCAFE);
      chk("bp_we", 32'(o_we), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_rel_v", 32'(o_rsp_valid), 32'd0);
    chk("bp_rel_ready", 32'(o_req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_acc_we", 32'(o_we), 32'd1);
    chk("bp_acc_wval", o_wval, 32'h55);
    finish_store("bp_st");

    // Reset during WAIT aborts the load
    rd_val = 32'h0BAD;
    req_valid = 1'b1; req_write = 1'b0; req_addr = IO_ADDR_BTN;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rw_ready", 32'(o_req_ready), 32'd1);
    chk("rw_rsp_v", 32'(o_rsp_valid), 32'd0);
    chk("rw_addr", o_addr, 32'd0);
    chk("rw_rdata", o_rdata, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rw_no_rsp", 32'(o_rsp_valid), 32'd0);
    end
    rd_val = 32'h77;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rw_ld_re", 32'(o_re), 32'd1);
    repeat (3) tick();
    chk("rw_ld_early", 32'(o_rsp_valid), 32'd0);
    tick();
    chk("rw_ld_v", 32'(o_rsp_valid), 32'd1);
    chk("rw_ld_d", o_rdata, 32'h77);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Back-to-back store then load, responses in order
    sel = 1'b0;
    rd_val = 32'h0000_A5A5;
    rsp_ready = 1'b1;
`ifndef IO_POSTED_WRITE_EN
    exp_q.push_back(32'd0);
`endif
    exp_q.push_back(32'h0000_A5A5);
    idx = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = IO_ADDR_LED; req_wdata = 32'hAB;
    for (int c = 0; c < 20; c++) begin
      acc = o_req_ready && req_valid;
      tick();
      chk("b2b_overlap", 32'(o_we && o_re), 32'd0);
      if (o_rsp_valid) rsp_q.push_back(o_rdata);
      if (acc) begin
        idx++;
        if (idx == 1) begin
          req_write = 1'b0; req_addr = IO_ADDR_SW;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    chk("b2b_count", 32'(rsp_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rsp_q.size()) chk("b2b_order", rsp_q[i], exp_q[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
